// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM stage: opcodes, load/store funct3 codes, FSM states
// and the alignment rule used to reject misaligned accesses.
package mem_access_unit_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_st_e;

  // Access size is funct3[1:0]; the offset must be a multiple of the size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane steering: store mask/shift into the doubleword and
// load shift/extend out of it.
module mem_lane_fmt
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      st_funct3,
  input  logic [2:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [7:0]      st_mask,
  output logic [XLEN-1:0] st_lanes,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_result
);

  logic [XLEN-1:0] ld_shift;

  always_comb begin
    case ({1'b0, st_funct3[1:0]})
      FUNCT3_SB: st_mask = 8'h01 << st_off;
      FUNCT3_SH: st_mask = 8'h03 << st_off;
      FUNCT3_SW: st_mask = 8'h0F << st_off;
      FUNCT3_SD: st_mask = 8'hFF;
      default:   st_mask = 8'h00;
    endcase
    st_lanes = st_data << {st_off, 3'b000};

    ld_shift = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      FUNCT3_LB:  ld_result = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      FUNCT3_LH:  ld_result = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      FUNCT3_LW:  ld_result = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      FUNCT3_LD:  ld_result = ld_shift;
      FUNCT3_LBU: ld_result = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      FUNCT3_LHU: ld_result = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      FUNCT3_LWU: ld_result = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
      default:    ld_result = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV64 MEM stage: issues loads/stores over a req/ack bus, stalls the pipeline
// while an access is outstanding, and passes non-memory results through.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd_addr_i,
  input  logic            wreg_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  output logic [4:0]      rd_addr_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            stall_req_o,
  output logic            misaligned_o,
  output logic            bus_err_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wmask_o,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_ack_i
);

  mem_st_e         state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            latch_en, capture;

  logic [XLEN-1:0] addr_p1, lanes_p1, result_p1;
  logic [7:0]      mask_p1;
  logic            we_p1;
  logic [2:0]      off_p1, funct3_p1;

  logic [2:0]      off;
  logic            is_load, is_store, is_mem, bad_mem, misal;
  logic [7:0]      st_mask;
  logic [XLEN-1:0] st_lanes, ld_result;

  assign off      = wdata_i[2:0];
  assign is_load  = (opcode_i == OPCODE_LOAD) && (funct3_i != 3'b111);
  assign is_store = (opcode_i == OPCODE_STORE) && !funct3_i[2];
  assign is_mem   = is_load || is_store;
  assign bad_mem  = ((opcode_i == OPCODE_LOAD) || (opcode_i == OPCODE_STORE)) && !is_mem;
  assign misal    = is_mem && is_misaligned(funct3_i, off);

  mem_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
    .st_funct3 (funct3_i),
    .st_off    (off),
    .st_data   (store_data_i),
    .st_mask   (st_mask),
    .st_lanes  (st_lanes),
    .ld_funct3 (funct3_p1),
    .ld_off    (off_p1),
    .ld_rdata  (dmem_rdata_i),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request fields and load result carry no reset; they are only observed behind the FSM.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      addr_p1   <= {wdata_i[XLEN-1:3], 3'b000};
      we_p1     <= is_store;
      mask_p1   <= is_store ? st_mask : 8'h00;
      lanes_p1  <= st_lanes;
      off_p1    <= off;
      funct3_p1 <= funct3_i;
    end
    if (capture) begin
      result_p1 <= ld_result;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    latch_en     = 1'b0;
    capture      = 1'b0;
    rd_addr_o    = '0;
    wreg_o       = 1'b0;
    wdata_o      = '0;
    stall_req_o  = 1'b0;
    misaligned_o = 1'b0;
    bus_err_o    = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_wmask_o = '0;

    case (state_q)
      MEM_ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (is_mem && !misal) begin
          state_d  = MEM_ST_BUSY;
          latch_en = 1'b1;
        end
      end
      MEM_ST_BUSY: begin
        if (dmem_ack_i) begin
          capture = !we_p1;
          state_d = MEM_ST_DONE;
          cnt_d   = '0;
        end else if (cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_d = MEM_ST_DONE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_ST_DONE: begin
        state_d = MEM_ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = MEM_ST_IDLE;
    endcase

    // Every output is forced low while reset is held.
    if (!rst) begin
      rd_addr_o = rd_addr_i;
      wdata_o   = wdata_i;
      case (state_q)
        MEM_ST_IDLE: begin
          wreg_o       = wreg_i && !is_mem && !bad_mem;
          misaligned_o = misal;
          stall_req_o  = is_mem && !misal;
        end
        MEM_ST_BUSY: begin
          stall_req_o  = 1'b1;
          dmem_req_o   = 1'b1;
          dmem_we_o    = we_p1;
          dmem_addr_o  = addr_p1;
          dmem_wdata_o = lanes_p1;
          dmem_wmask_o = mask_p1;
        end
        MEM_ST_DONE: begin
          bus_err_o = err_q;
          if (!err_q && !we_p1) begin
            wdata_o = result_p1;
            wreg_o  = wreg_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit with a byte-level reference model.
module tb_mem_access_unit;

  localparam int XLEN        = 64;
  localparam int ACK_TIMEOUT = 255;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      rd_addr_i;
  logic            wreg_i;
  logic [XLEN-1:0] wdata_i;
  logic [XLEN-1:0] store_data_i;
  logic [6:0]      opcode_i;
  logic [2:0]      funct3_i;
  logic [4:0]      rd_addr_o;
  logic            wreg_o;
  logic [XLEN-1:0] wdata_o;
  logic            stall_req_o;
  logic            misaligned_o;
  logic            bus_err_o;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [7:0]      dmem_wmask_o;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            dmem_ack_i;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_unit #(.XLEN(XLEN), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    (rd_addr_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .store_data_i (store_data_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .rd_addr_o    (rd_addr_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stall_req_o  (stall_req_o),
    .misaligned_o (misaligned_o),
    .bus_err_o    (bus_err_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wmask_o (dmem_wmask_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: gather access bytes from the doubleword, then extend.
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input logic [2:0] f3, input int off);
    int n = 1 << f3[1:0];
    logic [7:0] m = '0;
    for (int i = 0; i < n; i++) m[off+i] = 1'b1;
    return m;
  endfunction

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] wd,
                       input logic [63:0] sd, input logic [4:0] rd, input logic wr);
    opcode_i = opc; funct3_i = f3; wdata_i = wd; store_data_i = sd; rd_addr_i = rd; wreg_i = wr;
  endtask

  task automatic bubble();
    drive(OP_ADDI, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
  endtask

  task automatic pass_op(input logic [63:0] d, input logic [4:0] rd);
    @(posedge clk); #1;
    drive(OP_ADDI, 3'b000, d, 64'h0, rd, 1'b1);
    @(negedge clk);
    chk("pass_wdata", wdata_o, d);
    chk("pass_rd", 64'(rd_addr_o), 64'(rd));
    chk("pass_wreg", 64'(wreg_o), 64'd1);
    chk("pass_stall", 64'(stall_req_o), 64'd0);
    chk("pass_req", 64'(dmem_req_o), 64'd0);
  endtask

  task automatic mis_op(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] addr);
    @(posedge clk); #1;
    drive(opc, f3, addr, 64'h1234, 5'd9, opc == OP_LOAD);
    @(negedge clk);
    chk("mis_flag", 64'(misaligned_o), 64'd1);
    chk("mis_stall", 64'(stall_req_o), 64'd0);
    chk("mis_req", 64'(dmem_req_o), 64'd0);
    chk("mis_wreg", 64'(wreg_o), 64'd0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("mis_pulse", 64'(misaligned_o), 64'd0);
    chk("mis_req_after", 64'(dmem_req_o), 64'd0);
  endtask

  // ack_at < 0 withholds the ack so the access times out.
  task automatic mem_op(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sd, input logic [63:0] rdata, input int ack_at,
                        input logic [4:0] rd, input logic wr);
    int  busy = 0;
    int  req_cycles = 0;
    bit  done = 0;
    bit  is_st = (opc == OP_STORE);
    int  off = int'(addr[2:0]);
    @(posedge clk); #1;
    drive(opc, f3, addr, sd, rd, wr);
    dmem_rdata_i = rdata;
    @(negedge clk);
    chk("idle_stall", 64'(stall_req_o), 64'd1);
    chk("idle_req", 64'(dmem_req_o), 64'd0);
    while (busy < ACK_TIMEOUT + 40) begin
      @(posedge clk); #1;
      dmem_ack_i = (busy == ack_at);
      @(negedge clk);
      if (!stall_req_o) begin done = 1; break; end
      if (busy == 0) begin
        chk("busy_addr", dmem_addr_o, addr & ~64'h7);
        chk("busy_we", 64'(dmem_we_o), 64'(is_st));
        if (is_st) begin
          chk("busy_mask", 64'(dmem_wmask_o), 64'(model_mask(f3, off)));
          chk("busy_wdata", dmem_wdata_o, sd << (8*off));
        end
      end
      if (!dmem_req_o) chk("busy_req", 64'(dmem_req_o), 64'd1);
      req_cycles++;
      busy++;
    end
    dmem_ack_i = 1'b0;
    chk("busy_bound", 64'(done), 64'd1);
    chk("req_cycles", 64'(req_cycles), (ack_at >= 0) ? 64'(ack_at + 1) : 64'(ACK_TIMEOUT));
    chk("done_req", 64'(dmem_req_o), 64'd0);
    chk("done_err", 64'(bus_err_o), 64'(ack_at < 0));
    chk("done_wreg", 64'(wreg_o), (!is_st && ack_at >= 0) ? 64'(wr) : 64'd0);
    if (!is_st && ack_at >= 0) begin
      chk("load_data", wdata_o, model_load(f3, off, rdata));
      chk("load_rd", 64'(rd_addr_o), 64'(rd));
    end
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("after_err", 64'(bus_err_o), 64'd0);
    chk("after_stall", 64'(stall_req_o), 64'd0);
  endtask

  initial begin
    logic [63:0] addr, sd, rdv;
    logic [2:0]  f3;
    logic [6:0]  opc;
    int          n, off;

    rst = 1'b1;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = '0;
    drive(OP_ADDI, 3'b000, 64'h55, 64'h0, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wreg", 64'(wreg_o), 64'd0);
    chk("rst_wdata", wdata_o, 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    chk("rst_req", 64'(dmem_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    pass_op(64'h1234, 5'd5);
    mem_op(OP_LOAD, 3'b000, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 5'd7, 1'b1);
    mem_op(OP_STORE, 3'b001, 64'h2006, 64'hABCD, 64'h0, 1, 5'd0, 1'b0);
    mis_op(OP_LOAD, 3'b010, 64'h3002);
    mis_op(OP_STORE, 3'b011, 64'h3004);
    mis_op(OP_LOAD, 3'b101, 64'h3001);
    mem_op(OP_LOAD, 3'b011, 64'h4000, 64'h0, 64'hDEAD_BEEF_0000_0001, -1, 5'd8, 1'b1);

    // Reserved funct3: no access, no write-back, no flag.
    @(posedge clk); #1;
    drive(OP_LOAD, 3'b111, 64'h5000, 64'h0, 5'd4, 1'b1);
    @(negedge clk);
    chk("rsv_wreg", 64'(wreg_o), 64'd0);
    chk("rsv_stall", 64'(stall_req_o), 64'd0);
    chk("rsv_mis", 64'(misaligned_o), 64'd0);

    for (int i = 0; i < 24; i++) begin
      opc  = ($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD;
      f3   = (opc == OP_STORE) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      n    = 1 << f3[1:0];
      off  = (int'($urandom_range(0, 7)) / n) * n;
      addr = ({$urandom, $urandom} & ~64'h7) | 64'(off);
      sd   = {$urandom, $urandom};
      rdv  = {$urandom, $urandom};
      mem_op(opc, f3, addr, sd, rdv, int'($urandom_range(0, 3)), 5'($urandom_range(1, 31)),
             1'($urandom_range(0, 1)));
      if (i % 6 == 0) pass_op({$urandom, $urandom}, 5'($urandom_range(0, 31)));
    end

    // Reset in the middle of an outstanding load; the late ack must be ignored.
    @(posedge clk); #1;
    drive(OP_LOAD, 3'b011, 64'h6000, 64'h0, 5'd10, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_req", 64'(dmem_req_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_req", 64'(dmem_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bubble();
    dmem_ack_i = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 64'(dmem_req_o), 64'd0);
    chk("post_rst_stall", 64'(stall_req_o), 64'd0);
    chk("post_rst_wreg", 64'(wreg_o), 64'd0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_wreg", 64'(wreg_o), 64'd0);
    chk("late_ack_err", 64'(bus_err_o), 64'd0);
    pass_op(64'hCAFE, 5'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
